// File: rtl/seq_alu.sv
// seq_alu: sequential ALU, 1-cycle ops plus a WIDTH-cycle restoring divide.
// Ports: clk, rst_n, a, b, sel, in_valid/in_ready in; out, carryout, divzero, rem, out_valid/out_ready out.
// Macro SEQ_ALU_REM_EN: defined -> rem returns the divide remainder; undefined -> rem tied to 0.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             divzero,
  output logic [WIDTH-1:0] rem,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic             acc;
  logic             is_div;
  logic             last;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_c;

  logic [WIDTH:0]   rs;
  logic             ge;
  logic [WIDTH-1:0] r_nx;
  logic [WIDTH-1:0] q_nx;

  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign out_valid = (state == DONE);
  assign acc       = in_valid & in_ready;
  assign is_div    = (sel == 4'b0011);
  assign last      = (cnt == CW'(WIDTH - 1));

  assign sum  = {1'b0, a} + {1'b0, b};
  // top bit of the widened difference is the borrow
  assign dif  = {1'b0, a} - {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    alu_out = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    unique case (1'b1)
      sel == 4'b0001: begin
        alu_out = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
      end
      sel == 4'b0010: begin
        alu_out = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
      sel == 4'b0100: begin
        alu_out = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      sel == 4'b0101: begin
        alu_out = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      sel == 4'b0110: begin
        alu_out = a & b;
        alu_c   = 1'b0;
      end
      sel == 4'b0111: begin
        alu_out = a | b;
        alu_c   = 1'b0;
      end
      default: begin
        alu_out = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
    endcase
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. A zero divisor
  // always fits, giving all-ones quotient and remainder equal to a.
  assign rs   = {r, q[WIDTH-1]};
  assign ge   = (rs >= {1'b0, d});
  assign r_nx = ge ? WIDTH'(rs - {1'b0, d}) : rs[WIDTH-1:0];
  assign q_nx = {q[WIDTH-2:0], ge};

`ifdef SEQ_ALU_REM_EN
  logic [WIDTH-1:0] rem_q;
  assign rem = rem_q;
`else
  assign rem = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      q        <= '0;
      r        <= '0;
      d        <= '0;
      out      <= '0;
      carryout <= 1'b0;
      divzero  <= 1'b0;
`ifdef SEQ_ALU_REM_EN
      rem_q    <= '0;
`endif
    end else if (acc) begin
      if (is_div) begin
        state <= DIV;
        cnt   <= '0;
        q     <= a;
        r     <= '0;
        d     <= b;
      end else begin
        state    <= DONE;
        out      <= alu_out;
        carryout <= alu_c;
        divzero  <= 1'b0;
`ifdef SEQ_ALU_REM_EN
        rem_q    <= '0;
`endif
      end
    end else if (state == DIV) begin
      cnt <= cnt + CW'(1);
      q   <= q_nx;
      r   <= r_nx;
      if (last) begin
        state    <= DONE;
        out      <= q_nx;
        carryout <= 1'b0;
        divzero  <= (d == '0);
`ifdef SEQ_ALU_REM_EN
        rem_q    <= r_nx;
`endif
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed bench for seq_alu with a transaction-level model.
// Instances: 8-bit DUT (model-checked every cycle) and 16-bit DUT (directed).
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, carryout, divzero;
  logic [7:0] out, rem;

  logic [15:0] a16, b16, o16, rm16;
  logic [3:0]  s16;
  logic        iv16, ir16, ov16, c16, dz16;
  logic        or16 = 1'b1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .carryout(carryout), .divzero(divzero), .rem(rem),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .sel(s16),
    .in_valid(iv16), .in_ready(ir16), .out(o16),
    .carryout(c16), .divzero(dz16), .rem(rm16),
    .out_valid(ov16), .out_ready(or16)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Result of one operation from plain integer arithmetic.
  function automatic void ref_op(input int unsigned x, y,
                                 input logic [3:0] s,
                                 output logic [7:0] o,
                                 output logic c, dz,
                                 output logic [7:0] rm);
    int unsigned t;
    o = 8'd0; c = 1'b0; dz = 1'b0; rm = 8'd0;
    case (s)
      4'd1: begin o = 8'((x - y) & 255); c = (x < y); end
      4'd2: begin t = x * y; o = 8'(t); c = (t > 255); end
      4'd3: begin
        if (y == 0) begin o = 8'hFF; dz = 1'b1; rm = 8'(x); end
        else begin o = 8'(x / y); rm = 8'(x % y); end
      end
      4'd4: begin o = 8'(x * 2); c = (x >= 128); end
      4'd5: begin o = 8'(x / 2); c = (x % 2 == 1); end
      4'd6: o = 8'(x & y);
      4'd7: o = 8'(x | y);
      default: begin t = x + y; o = 8'(t); c = (t > 255); end
    endcase
`ifndef SEQ_ALU_REM_EN
    rm = 8'd0;
`endif
  endfunction

  logic [7:0] n_out, n_rem;
  logic       n_c, n_dz;
  always_comb begin
    n_out = 8'd0; n_rem = 8'd0; n_c = 1'b0; n_dz = 1'b0;
    ref_op({24'd0, a}, {24'd0, b}, sel, n_out, n_c, n_dz, n_rem);
  end

  // Model: a divide is busy for 8 cycles after acceptance, any other op
  // shows its result right after acceptance; a result is held until taken.
  int         m_busy = 0;
  bit         m_hold = 1'b0;
  logic [7:0] m_out = 8'd0, m_rem = 8'd0, p_out = 8'd0, p_rem = 8'd0;
  logic       m_c = 1'b0, m_dz = 1'b0, p_c = 1'b0, p_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hold <= 1'b0;
      m_out <= 8'd0; m_rem <= 8'd0; m_c <= 1'b0; m_dz <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_hold <= 1'b1;
        m_out <= p_out; m_rem <= p_rem; m_c <= p_c; m_dz <= p_dz;
      end
    end else if (in_valid && (!m_hold || out_ready)) begin
      if (sel == 4'd3) begin
        m_busy <= 8; m_hold <= 1'b0;
        p_out <= n_out; p_rem <= n_rem; p_c <= n_c; p_dz <= n_dz;
      end else begin
        m_hold <= 1'b1;
        m_out <= n_out; m_rem <= n_rem; m_c <= n_c; m_dz <= n_dz;
      end
    end else if (m_hold && out_ready) begin
      m_hold <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_in_ready", 32'(in_ready),
          32'((m_busy == 0) && (!m_hold || out_ready)));
      chk("mon_out_valid", 32'(out_valid), 32'(m_hold));
      chk("mon_out", 32'(out), 32'(m_out));
      chk("mon_carryout", 32'(carryout), 32'(m_c));
      chk("mon_divzero", 32'(divzero), 32'(m_dz));
      chk("mon_rem", 32'(rem), 32'(m_rem));
    end
  end

  // Issue one request from IDLE (called 1 time unit after a rising edge),
  // wait for the result and check it against hand-computed values.
  task automatic op(input bit w16, input logic [15:0] ta, tb,
                    input logic [3:0] ts, input logic [15:0] eo,
                    input logic ec, edz, input logic [15:0] erm,
                    input int elat, input string nm);
    int lat;
    logic [15:0] ao, arm;
    logic ac, adz, av;
    if (w16) begin a16 = ta; b16 = tb; s16 = ts; iv16 = 1'b1; end
    else begin a = ta[7:0]; b = tb[7:0]; sel = ts; in_valid = 1'b1; end
    @(posedge clk); #1;
    in_valid = 1'b0; iv16 = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); s16 = 4'($urandom);
    lat = 1;
    av = w16 ? ov16 : out_valid;
    while (!av && lat < 40) begin
      chk({nm, "_busy_in_ready"}, 32'(w16 ? ir16 : in_ready), 0);
      @(posedge clk); #1;
      lat++;
      av = w16 ? ov16 : out_valid;
    end
    if (w16) begin ao = o16; arm = rm16; ac = c16; adz = dz16; end
    else begin ao = {8'd0, out}; arm = {8'd0, rem}; ac = carryout; adz = divzero; end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_out"}, 32'(ao), 32'(eo));
    chk({nm, "_carryout"}, 32'(ac), 32'(ec));
    chk({nm, "_divzero"}, 32'(adz), 32'(edz));
`ifdef SEQ_ALU_REM_EN
    chk({nm, "_rem"}, 32'(arm), 32'(erm));
`else
    chk({nm, "_rem"}, 32'(arm), 0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; sel = 4'd0;
    iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; s16 = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_carryout", 32'(carryout), 0);
    chk("rst_divzero", 32'(divzero), 0);
    chk("rst_rem", 32'(rem), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    op(0, 16'hF0, 16'h20, 4'd0, 16'h10, 1, 0, 16'h0, 1, "add_f0_20");
    op(0, 16'd200, 16'd7, 4'd3, 16'd28, 0, 0, 16'd4, 9, "div_200_7");
    op(0, 16'd5, 16'd9, 4'd3, 16'd0, 0, 0, 16'd5, 9, "div_a_lt_b");
    op(0, 16'd3, 16'd5, 4'd1, 16'hFE, 1, 0, 16'h0, 1, "sub_3_5");
    op(0, 16'd5, 16'd3, 4'd1, 16'h02, 0, 0, 16'h0, 1, "sub_5_3");
    op(0, 16'h10, 16'h20, 4'd2, 16'h00, 1, 0, 16'h0, 1, "mul_ovf");
    op(0, 16'd7, 16'd9, 4'd2, 16'h3F, 0, 0, 16'h0, 1, "mul_7_9");
    op(0, 16'h81, 16'h00, 4'd4, 16'h02, 1, 0, 16'h0, 1, "shl_81");
    op(0, 16'h81, 16'h00, 4'd5, 16'h40, 1, 0, 16'h0, 1, "shr_81");
    op(0, 16'hF0, 16'h3C, 4'd6, 16'h30, 0, 0, 16'h0, 1, "and");
    op(0, 16'hF0, 16'h0C, 4'd7, 16'hFC, 0, 0, 16'h0, 1, "or");
    op(0, 16'h01, 16'h01, 4'hF, 16'h02, 0, 0, 16'h0, 1, "sel_f_add");
    op(0, 16'hFF, 16'h01, 4'hA, 16'h00, 1, 0, 16'h0, 1, "sel_a_add");

    // result held while the consumer stalls, then back-to-back traffic
    out_ready = 1'b0;
    a = 8'h12; b = 8'h34; sel = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      chk("hold_out", 32'(out), 32'h46);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    a = 8'd3; b = 8'd5; sel = 4'd1; in_valid = 1'b1;
    #1 chk("b2b_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_out_valid", 32'(out_valid), 1);
    chk("b2b_out", 32'(out), 32'hFE);
    chk("b2b_carryout", 32'(carryout), 1);
    a = 8'd100; b = 8'd10; sel = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_div_valid", 32'(out_valid), 0);
    chk("b2b_div_out_kept", 32'(out), 32'hFE);
    repeat (8) @(posedge clk);
    #1;
    chk("b2b_div_done", 32'(out_valid), 1);
    chk("b2b_div_out", 32'(out), 32'd10);
    @(posedge clk); #1;

    op(0, 16'h55, 16'h00, 4'd3, 16'hFF, 0, 1, 16'h55, 9, "div_by_zero");

    // reset in the 4th divide cycle clears everything at once
    a = 8'd200; b = 8'd7; sel = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(out), 0);
    chk("midrst_carryout", 32'(carryout), 0);
    chk("midrst_divzero", 32'(divzero), 0);
    chk("midrst_rem", 32'(rem), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op(0, 16'd1, 16'd2, 4'd0, 16'd3, 0, 0, 16'h0, 1, "post_rst_add");
    repeat (12) @(posedge clk);
    #1;

    op(1, 16'h0300, 16'h0100, 4'd2, 16'h0000, 1, 0, 16'h0, 1, "w16_mul");
    op(1, 16'h0001, 16'h0001, 4'hF, 16'h0002, 0, 0, 16'h0, 1, "w16_sel_f");
    op(1, 16'd1000, 16'd3, 4'd3, 16'd333, 0, 0, 16'd1, 17, "w16_div");

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 sel  input  4  operation select.
REQ-007 in_valid  input  1  operands and sel are valid.
REQ-008 in_ready  output  1  block accepts a request this cycle.
REQ-009 out  output  WIDTH  result.
REQ-010 carryout  output  1  carry, borrow or overflow flag for the result.
REQ-011 divzero  output  1  result came from a division by zero.
REQ-012 rem  output  WIDTH  division remainder; see Configuration.
REQ-013 out_valid  output  1  out, carryout, divzero and rem are valid.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 A request is accepted on a rising edge where in_valid=1 and in_ready=1; a, b and sel are captured on that edge.
REQ-016 Operation encoding:
- 0000: add; out=(a+b) mod 2^WIDTH, carryout=bit WIDTH of the sum.
- 0001: subtract; out=(a-b) mod 2^WIDTH, carryout=1 when a<b (borrow).
- 0010: multiply; out=low WIDTH bits of a*b, carryout=1 when the high WIDTH bits are nonzero.
- 0011: unsigned divide; out=a/b.
- 0100: out=a<<1, carryout=a[WIDTH-1].
- 0101: out=a>>1, carryout=a[0].
- 0110: out=a&b, carryout=0.
- 0111: out=a|b, carryout=0.
- 1000..1111: treated as add.
REQ-017 State machine has three states:
- IDLE: in_ready=1, out_valid=0.
- DIV: in_ready=0, out_valid=0; one iteration of restoring division per cycle.
- DONE: out_valid=1; outputs held stable.
REQ-018 IDLE transitions on acceptance: to DONE on the next edge for non-divide ops (latency 1), to DIV for divide.
REQ-019 DIV runs exactly WIDTH cycles, then moves to DONE; divide latency from acceptance to out_valid is WIDTH+1 cycles.
REQ-020 In DONE, in_ready=out_ready. A result transfers on an edge with out_valid=1 and out_ready=1; with in_valid=0 on that edge the state returns to IDLE.
REQ-021 Simultaneous transfer and acceptance in DONE (out_ready=1, in_valid=1) starts the new operation on the same edge: the next state is DONE (non-divide) or DIV (divide), with no idle bubble.
REQ-022 out, carryout, divzero and rem are registered and change only on the edge that enters DONE.
REQ-023 Divide with b=0 completes through DIV with the normal latency and gives out=all ones, rem=a, carryout=0, divzero=1; divzero=0 for every other result.
REQ-024 Divide with a<b gives out=0, rem=a, carryout=0.
REQ-025 Input changes while in DIV or DONE have no effect on the operation in flight.

Reset
REQ-026 rst_n=0 forces state IDLE immediately, independent of clk: out=0, carryout=0, divzero=0, rem=0, out_valid=0, in_ready=1.
REQ-027 Reset asserted mid-divide or while DONE is holding a result discards that operation; no out_valid is produced for it after reset releases.
REQ-028 The first request is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro SEQ_ALU_REM_EN.
- Defined: rem carries the division remainder per REQ-023/REQ-024, and rem=0 for non-divide ops.
- Undefined: rem is tied to 0 at all times and no remainder register is implemented.
- All other behaviour, including divide latency, is identical in both builds.

Verification
REQ-030 WIDTH=8, add a=0xF0 b=0x20 -> out=0x10, carryout=1, out_valid exactly one cycle after acceptance.
REQ-031 WIDTH=8, divide a=200 b=7 -> out=28, out_valid 9 cycles after acceptance, in_ready=0 during DIV; with SEQ_ALU_REM_EN, rem=4.
REQ-032 Divide a=0x55 b=0 -> out=0xFF, divzero=1, carryout=0; with SEQ_ALU_REM_EN, rem=0x55.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 carrying sub a=3 b=5 -> back-to-back accept, next result out=0xFE, carryout=1.
REQ-034 Assert rst_n=0 in the 4th DIV cycle -> all outputs zero asynchronously, in_ready=1, no stale out_valid after release.
REQ-035 WIDTH=16, multiply a=0x0300 b=0x0100 -> out=0x0000, carryout=1; sel=1111 a=1 b=1 -> out=2.
